// File: rtl/mixer_share_pkg.sv
// Shared widths, pipeline latency and product-slice helper for the shared mixer.
package mixer_share_pkg;
  localparam int DEF_NCH  = 4;
  localparam int DEF_CW   = 2;
  localparam int DEF_DWI  = 16;
  localparam int DEF_DWLO = 18;
  localparam int DEF_DAVR = 4;
  localparam int DEF_DROP = 1;
  localparam int LAT      = 4;

  typedef struct packed {
    int hi;
    int lo;
  } slice_t;

  // Keep dwi+davr bits of the product after discarding redundant sign bits.
  function automatic slice_t slice_bounds(int dwi, int dwlo, int davr, int drop);
    slice_t sb;
    sb.hi = dwi + dwlo - drop - 1;
    sb.lo = dwlo - davr - drop;
    return sb;
  endfunction
endpackage

// File: rtl/mixer_share_arb_rr_arbiter.sv
// Round-robin arbiter: searches req upward from a rotating pointer, one grant per cycle.
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [NCH-1:0] req,
  output logic [NCH-1:0] grant,
  output logic [CW-1:0]  idx,
  output logic           gvalid
);
  logic [CW-1:0] ptr_reg, ptr_next;

  always_comb begin
    int c;
    c      = 0;
    grant  = '0;
    idx    = '0;
    gvalid = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      c = int'(ptr_reg) + i;
      if (c >= NCH) c = c - NCH;
      if (!gvalid && req[c]) begin
        gvalid = 1'b1;
        idx    = CW'(c);
      end
    end
    if (!en || rst) gvalid = 1'b0;
    if (gvalid) grant[idx] = 1'b1;
  end

  // Explicit wrap keeps the pointer inside 0..NCH-1 for non-power-of-two NCH.
  always_comb begin
    ptr_next = ptr_reg;
    if (gvalid) ptr_next = (idx == CW'(NCH - 1)) ? '0 : idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_reg <= '0;
    else     ptr_reg <= ptr_next;
  end
endmodule

// File: rtl/mixer_share_arb.sv
// Round-robin shared mixer: one operand pair per cycle through a 4-stage multiply/slice pipe.
module mixer_share_arb
  import mixer_share_pkg::*;
#(
  parameter int NCH           = DEF_NCH,
  parameter int CW            = DEF_CW,
  parameter int dwi           = DEF_DWI,
  parameter int dwlo          = DEF_DWLO,
  parameter int davr          = DEF_DAVR,
  parameter int NUM_DROP_BITS = DEF_DROP
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NCH-1:0]             req,
  input  logic [NCH*dwi-1:0]         adc_bus,
  input  logic [NCH*dwlo-1:0]        lo_bus,
  output logic [NCH-1:0]             grant,
  output logic                       out_valid,
  output logic [CW-1:0]              out_ch,
  output logic signed [dwi+davr-1:0] mixout,
  output logic                       busy
);
  localparam slice_t SB  = slice_bounds(dwi, dwlo, davr, NUM_DROP_BITS);
  localparam int     SHI = SB.hi;
  localparam int     SLO = SB.lo;
  localparam int     PW  = dwi + dwlo;

  logic signed [dwi-1:0]  adc_arr [NCH];
  logic signed [dwlo-1:0] lo_arr  [NCH];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
    assign adc_arr[gi] = adc_bus[gi*dwi +: dwi];
    assign lo_arr[gi]  = lo_bus[gi*dwlo +: dwlo];
  end

  logic [CW-1:0] sel_idx;
  logic          sel_valid;

  rr_arbiter #(.NCH(NCH), .CW(CW)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .req    (req),
    .grant  (grant),
    .idx    (sel_idx),
    .gvalid (sel_valid)
  );

  logic [LAT-1:0]           vld_reg;
  logic signed [dwi-1:0]    adc1_reg;
  logic signed [dwlo-1:0]   lo1_reg;
  logic [CW-1:0]            tag1_reg, tag2_reg, tag3_reg, tag4_reg;
  logic signed [PW-1:0]     prod2_reg;
  logic [dwi+davr-1:0]      slice3_reg, mix4_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_reg <= '0;
    else     vld_reg <= {vld_reg[LAT-2:0], sel_valid};
  end

  // Data stages load only behind a valid token so outputs hold between results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc1_reg   <= '0;
      lo1_reg    <= '0;
      tag1_reg   <= '0;
      prod2_reg  <= '0;
      tag2_reg   <= '0;
      slice3_reg <= '0;
      tag3_reg   <= '0;
      mix4_reg   <= '0;
      tag4_reg   <= '0;
    end else begin
      if (sel_valid) begin
        adc1_reg <= adc_arr[sel_idx];
        lo1_reg  <= lo_arr[sel_idx];
        tag1_reg <= sel_idx;
      end
      if (vld_reg[0]) begin
        prod2_reg <= PW'(adc1_reg) * PW'(lo1_reg);
        tag2_reg  <= tag1_reg;
      end
      if (vld_reg[1]) begin
        slice3_reg <= prod2_reg[SHI:SLO];
        tag3_reg   <= tag2_reg;
      end
      if (vld_reg[2]) begin
        mix4_reg <= slice3_reg;
        tag4_reg <= tag3_reg;
      end
    end
  end

  assign out_valid = vld_reg[LAT-1];
  assign out_ch    = tag4_reg;
  assign mixout    = mix4_reg;
  assign busy      = |vld_reg;
endmodule

// File: tb/tb_mixer_share_arb.sv
// Bench for mixer_share_arb: NCH=4 and NCH=3 instances against a queue-style reference model.
module tb_mixer_share_arb;
  import mixer_share_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;

  logic [3:0]  req4 = '0;
  logic [63:0] adc4 = '0;
  logic [71:0] lo4  = '0;
  logic [3:0]  grant4;
  logic        out_valid4, busy4;
  logic [1:0]  out_ch4;
  logic [19:0] mixout4;

  logic [2:0]  req3 = '0;
  logic [47:0] adc3 = '0;
  logic [53:0] lo3  = '0;
  logic [2:0]  grant3;
  logic        out_valid3, busy3;
  logic [1:0]  out_ch3;
  logic [19:0] mixout3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int          mptr    [2];
  bit          exp_v   [2][4096];
  int          exp_ch  [2][4096];
  logic [19:0] exp_d   [2][4096];
  int          last_ch [2];
  logic [19:0] last_d  [2];

  always #5 clk = ~clk;

  mixer_share_arb #(.NCH(4), .CW(2)) dut4 (
    .clk(clk), .rst(rst), .en(en), .req(req4), .adc_bus(adc4), .lo_bus(lo4),
    .grant(grant4), .out_valid(out_valid4), .out_ch(out_ch4), .mixout(mixout4), .busy(busy4)
  );

  mixer_share_arb #(.NCH(3), .CW(2)) dut3 (
    .clk(clk), .rst(rst), .en(en), .req(req3), .adc_bus(adc3), .lo_bus(lo3),
    .grant(grant3), .out_valid(out_valid3), .out_ch(out_ch3), .mixout(mixout3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Mixed value = floor(adc*lo / 2^13), wrapped to 20 bits.
  function automatic logic [19:0] mix_ref(input logic [15:0] a, input logic [17:0] b);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = (sa * sb) >>> 13;
    return p[19:0];
  endfunction

  task automatic grant_phase();
    for (int d = 0; d < 2; d++) begin
      int n, k, p;
      logic [3:0] r, eg, og;
      n  = (d == 0) ? 4 : 3;
      r  = (d == 0) ? req4 : {1'b0, req3};
      og = (d == 0) ? grant4 : {1'b0, grant3};
      k  = -1;
      eg = '0;
      if (en && !rst)
        for (int i = 0; i < n; i++) begin
          p = (mptr[d] + i) % n;
          if (k < 0 && r[p]) k = p;
        end
      if (k >= 0) eg[k] = 1'b1;
      chk($sformatf("grant_n%0d", n), {60'd0, og}, {60'd0, eg});
      if (k >= 0) begin
        mptr[d] = (k + 1) % n;
        exp_v[d][cyc+LAT]  = 1'b1;
        exp_ch[d][cyc+LAT] = k;
        if (d == 0) exp_d[d][cyc+LAT] = mix_ref(adc4[k*16 +: 16], lo4[k*18 +: 18]);
        else        exp_d[d][cyc+LAT] = mix_ref(adc3[k*16 +: 16], lo3[k*18 +: 18]);
      end
    end
  endtask

  task automatic out_phase();
    for (int d = 0; d < 2; d++) begin
      bit eb;
      logic ov, ob;
      logic [1:0] oc;
      logic [19:0] om;
      ov = (d == 0) ? out_valid4 : out_valid3;
      ob = (d == 0) ? busy4 : busy3;
      oc = (d == 0) ? out_ch4 : out_ch3;
      om = (d == 0) ? mixout4 : mixout3;
      if (exp_v[d][cyc]) begin
        last_ch[d] = exp_ch[d][cyc];
        last_d[d]  = exp_d[d][cyc];
      end
      eb = 1'b0;
      for (int j = 0; j < LAT; j++) eb = eb | exp_v[d][cyc+j];
      chk($sformatf("out_valid%0d", d), {63'd0, ov}, {63'd0, exp_v[d][cyc]});
      chk($sformatf("out_ch%0d", d), {62'd0, oc}, 64'(last_ch[d]));
      chk($sformatf("mixout%0d", d), {44'd0, om}, {44'd0, last_d[d]});
      chk($sformatf("busy%0d", d), {63'd0, ob}, {63'd0, eb});
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      grant_phase();
      @(posedge clk);
      #1;
      cyc++;
      out_phase();
    end
  endtask

  task automatic reset_now();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      mptr[d] = 0;
      last_ch[d] = 0;
      last_d[d] = '0;
      for (int j = 0; j <= LAT; j++) exp_v[d][cyc+j] = 1'b0;
    end
    #1;
    out_phase();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      mptr[d] = 0;
      last_ch[d] = 0;
      last_d[d] = '0;
    end
    // Reset: outputs zero and no grant even with requests pending.
    en = 1'b1; req4 = 4'b1111; req3 = 3'b111;
    run(2);
    rst = 1'b0; req4 = '0; req3 = '0;
    run(1);

    // Single channel, positive full-scale-ish product.
    adc4[1*16 +: 16] = 16'd16384; lo4[1*18 +: 18] = 18'd65536;
    req4 = 4'b0010;
    run(1);
    req4 = 4'b0000;
    run(5);
    chk("plan_single", {44'd0, mixout4}, 64'h20000);

    // Sign handling and floor truncation.
    adc4[2*16 +: 16] = 16'hC000; lo4[2*18 +: 18] = 18'd65536;
    adc4[3*16 +: 16] = 16'hFFFF; lo4[3*18 +: 18] = 18'd1;
    req4 = 4'b0100; run(1);
    req4 = 4'b1000; run(1);
    req4 = 4'b0000; run(6);

    // All requesting continuously: rotating grants, back-to-back outputs.
    for (int i = 0; i < 10; i++) begin
      adc4 = {$urandom, $urandom}; lo4 = {8'($urandom), $urandom, $urandom};
      req4 = 4'b1111;
      run(1);
    end
    req4 = '0; run(5);

    // NCH=3 wrap, then lone request on channel 2 while ptr sits at 0.
    adc3 = {16'($urandom), $urandom}; lo3 = {22'($urandom), $urandom};
    req3 = 3'b111; run(3);
    req3 = 3'b100; run(1);
    req3 = 3'b001; run(1);
    req3 = 3'b111; run(4);
    req3 = '0; run(5);

    // en low: pipeline drains, arbitration resumes from saved pointer.
    req4 = 4'b0110; run(2);
    req4 = 4'b1111; req3 = 3'b111; en = 1'b0;
    run(5);
    en = 1'b1;
    run(3);
    req4 = '0; req3 = '0; run(5);

    // Reset two cycles after a grant discards the in-flight token.
    req4 = 4'b0100; run(1);
    req4 = '0; run(2);
    reset_now();
    req4 = 4'b1111; run(2);
    rst = 1'b0; req4 = '0;
    run(6);
    req4 = 4'b1111; run(2);
    req4 = '0; run(5);

    // Randomized traffic including extreme operands.
    for (int i = 0; i < 300; i++) begin
      req4 = 4'($urandom); req3 = 3'($urandom);
      en   = ($urandom_range(0, 9) != 0);
      adc4 = {$urandom, $urandom}; lo4 = {8'($urandom), $urandom, $urandom};
      adc3 = {16'($urandom), $urandom}; lo3 = {22'($urandom), $urandom};
      if ($urandom_range(0, 7) == 0) begin
        adc4 = {4{16'h8000}}; lo4 = {4{18'h20000}};
      end
      run(1);
    end
    req4 = '0; req3 = '0;
    run(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
